// File: rtl/acc_pkg.sv
// Shared constants for the frame accumulator sequencer: state encoding and default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package acc_pkg;

  // Default width of the frame-length input and of the sample counter.
  localparam int LEN_W_DEF = 8;

  // Width of the sample path presented to the downstream accumulator.
  localparam int DATA_W = 8;

  // State encoding, kept as plain constants so other blocks can decode state.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_INIT = S_INIT,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/acc_frame_cnt.sv
// Counts accepted samples within a frame and flags the acceptance that completes it.
// Latency: tc_o is combinational from inc_i and the count; the count updates one edge later.
// Backpressure: none; increments only when the parent reports an accepted sample.
//
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : synchronous clear (wins over increment)
//   inc_i          : one accepted sample this cycle
//   len_i          : latched frame length
//   tc_o           : this increment brings the count to len_i
module acc_frame_cnt
  import acc_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             tc_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   cnt_plus1;

  // One extra bit so a full-scale length compares cleanly without wrapping.
  assign cnt_plus1 = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign tc_o      = inc_i && (cnt_plus1 == {1'b0, len_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_plus1[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_seq_8bit.sv
// Frame sequencer feeding an 8-bit accumulator: clear strobe, then one add strobe per accepted sample.
// Latency: accepted sample appears on o_in/o_enable one cycle after the i_valid & o_ready handshake.
// Backpressure: o_ready is high only in RUN; it drops once the final sample of the frame is taken.
//
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_start, i_len      : frame request and length, taken in IDLE when length is non-zero
//   i_valid, i_data     : upstream sample handshake, o_ready is the matching ready
//   o_init, o_enable,
//   o_in                : accumulator clear strobe, add strobe and sample
//   o_busy, o_done      : frame in progress (INIT/RUN), one-cycle completion pulse
//   i_abort             : present only when ACC_SEQ_ABORT_EN is defined; drops an
//                         in-progress frame without o_done
module acc_seq_8bit
  import acc_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
`ifdef ACC_SEQ_ABORT_EN
  input  logic              i_abort,
`endif
  output logic              o_ready,
  output logic              o_init,
  output logic              o_enable,
  output logic [DATA_W-1:0] o_in,
  output logic              o_busy,
  output logic              o_done
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic                init_q, busy_q, done_q, enable_q;
  logic [DATA_W-1:0]   in_q;
  logic                accept;
  logic                last_accept;
  logic                cnt_clr;

  // Ready is a pure decode of the state register, so it never depends on i_valid.
  assign o_ready = (state_q == ST_RUN);
  assign accept  = i_valid && o_ready;
  assign cnt_clr = (state_q != ST_RUN);

  acc_frame_cnt #(
    .LEN_W (LEN_W)
  ) u_frame_cnt (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (accept),
    .len_i   (len_q),
    .tc_o    (last_accept)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start && (i_len != '0)) state_d = ST_INIT;
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  if (last_accept) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef ACC_SEQ_ABORT_EN
    // Abort overrides completion, so a frame aborted on its last sample gets no o_done.
    if (i_abort && ((state_q == ST_INIT) || (state_q == ST_RUN))) begin
      state_d = ST_IDLE;
    end
`endif
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      init_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      if ((state_q == ST_IDLE) && (state_d == ST_INIT)) begin
        len_q <= i_len;
      end
      init_q   <= (state_d == ST_INIT);
      busy_q   <= (state_d == ST_INIT) || (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
      // The add strobe follows acceptance regardless of the next state, so a
      // sample taken in the same cycle as an abort or the final sample still lands.
      enable_q <= accept;
      if (accept) begin
        in_q <= i_data;
      end
    end
  end

  assign o_init   = init_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_enable = enable_q;
  assign o_in     = in_q;

endmodule

// File: tb/tb_acc_seq_8bit.sv
// Directed bench for acc_seq_8bit with a downstream accumulator model.
// Latency: checks the one-cycle sample latency and strobe alignment.
// Backpressure: drives continuous and toggling i_valid against o_ready.
module tb_acc_seq_8bit;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len   = 8'd0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'd0;
`ifdef ACC_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       o_ready, o_init, o_enable, o_busy, o_done;
  logic [7:0] o_in;

  int n_vec = 0;
  int n_err = 0;

  // Running totals gathered on the falling edge; tests compare deltas.
  int en_tot = 0, done_tot = 0, busy_tot = 0, init_tot = 0, sum_tot = 0, contig_tot = 0;
  int done_in = 0, done_en = 0;
  bit prev_en = 1'b0;
  int b_en, b_done, b_busy, b_init, b_sum, b_contig;

  acc_seq_8bit #(.LEN_W(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_len    (len),
    .i_valid  (valid),
    .i_data   (data),
`ifdef ACC_SEQ_ABORT_EN
    .i_abort  (abort),
`endif
    .o_ready  (o_ready),
    .o_init   (o_init),
    .o_enable (o_enable),
    .o_in     (o_in),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_enable) begin
      en_tot++;
      sum_tot += int'(o_in);
      if (prev_en) contig_tot++;
    end
    if (o_done) begin
      done_tot++;
      done_in = int'(o_in);
      done_en = int'(o_enable);
    end
    if (o_busy) busy_tot++;
    if (o_init) init_tot++;
    prev_en = o_enable;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_en = en_tot; b_done = done_tot; b_busy = busy_tot;
    b_init = init_tot; b_sum = sum_tot; b_contig = contig_tot;
  endtask

  // Start a frame of n samples with data 1,2,3,...; i_len is scrambled after
  // the start edge to show it is no longer looked at.
  task automatic run_frame(input logic [7:0] n, input bit toggle, input int budget);
    logic [7:0] d;
    bit v;
    bit acc;
    int cyc;
    start = 1'b1; len = n; tick();
    start = 1'b0; len = ~n;
    d = 8'd1; v = 1'b1; cyc = 0;
    while (!o_done && cyc < budget) begin
      valid = v; data = d;
      acc = v && o_ready;
      tick();
      if (acc) d = d + 8'd1;
      if (toggle) v = !v;
      cyc++;
    end
    check("frame reached o_done within budget", int'(o_done), 1);
    valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #3 rst_n = 1'b0;
    start = 1'b1; valid = 1'b1; len = 8'd5; data = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs {ready,init,enable,busy,done,o_in}",
          int'({o_ready, o_init, o_enable, o_busy, o_done, o_in}), 0);
    start = 1'b0; valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle after reset busy", int'(o_busy), 0);

    // Three-sample frame, stepped cycle by cycle; i_start held through the
    // frame and into DONE with a different length must be ignored.
    snap();
    start = 1'b1; len = 8'd3; tick();
    check("INIT o_init", int'(o_init), 1);
    check("INIT {busy,ready,enable}", int'({o_busy, o_ready, o_enable}), 3'b100);
    len = 8'd2; valid = 1'b1; data = 8'd1; tick();
    check("RUN entry {ready,init,enable}", int'({o_ready, o_init, o_enable}), 3'b100);
    tick();
    check("sample1 {enable,o_in}", int'({o_enable, o_in}), {1'b1, 8'd1});
    data = 8'd2; tick();
    check("sample2 {enable,o_in}", int'({o_enable, o_in}), {1'b1, 8'd2});
    data = 8'd3; tick();
    check("DONE {done,enable,o_in}", int'({o_done, o_enable, o_in}), {2'b11, 8'd3});
    check("DONE {ready,busy}", int'({o_ready, o_busy}), 0);
    valid = 1'b0; tick();
    check("start in DONE not queued {init,enable,done}", int'({o_init, o_enable, o_done}), 0);
    start = 1'b0; tick();
    check("back in IDLE busy", int'(o_busy), 0);
    check("len3 enables", en_tot - b_en, 3);
    check("len3 done pulses", done_tot - b_done, 1);
    check("len3 accumulated sum", sum_tot - b_sum, 6);
    check("len3 busy cycles", busy_tot - b_busy, 4);
    check("len3 init cycles", init_tot - b_init, 1);

    // Zero-length start must not leave IDLE.
    snap();
    start = 1'b1; len = 8'd0; tick();
    check("len0 {init,busy,ready}", int'({o_init, o_busy, o_ready}), 0);
    start = 1'b0; tick();
    check("len0 busy next cycle", int'(o_busy), 0);
    check("len0 init cycles", init_tot - b_init, 0);

    // Four samples with i_valid toggling.
    snap();
    run_frame(8'd4, 1'b1, 40);
    check("len4 enables", en_tot - b_en, 4);
    check("len4 contiguous enables", contig_tot - b_contig, 0);
    check("len4 done pulses", done_tot - b_done, 1);
    check("len4 sum", sum_tot - b_sum, 10);
    check("len4 enable at done", done_en, 1);
    check("len4 o_in at done", done_in, 4);

    // Full-scale frame length.
    snap();
    run_frame(8'd255, 1'b0, 400);
    check("len255 enables", en_tot - b_en, 255);
    check("len255 done pulses", done_tot - b_done, 1);
    check("len255 busy cycles", busy_tot - b_busy, 256);
    check("len255 sum", sum_tot - b_sum, 32640);
    check("len255 o_in at done", done_in, 255);

    // Reset in the middle of a five-sample frame.
    snap();
    start = 1'b1; len = 8'd5; tick();
    start = 1'b0; valid = 1'b1; data = 8'd1; tick();
    tick();
    data = 8'd2; tick();
    #5;
    rst_n = 1'b0;
    #1;
    check("mid-frame reset outputs", int'({o_ready, o_init, o_enable, o_busy, o_done, o_in}), 0);
    valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("after reset {busy,enable}", int'({o_busy, o_enable}), 0);
    check("reset frame enables", en_tot - b_en, 2);
    check("reset frame done pulses", done_tot - b_done, 0);
    snap();
    run_frame(8'd5, 1'b0, 20);
    check("post-reset len5 enables", en_tot - b_en, 5);
    check("post-reset len5 done pulses", done_tot - b_done, 1);
    check("post-reset len5 sum", sum_tot - b_sum, 15);

`ifdef ACC_SEQ_ABORT_EN
    // Abort after two samples while a third is accepted in the abort cycle.
    snap();
    start = 1'b1; len = 8'd5; tick();
    start = 1'b0; valid = 1'b1; data = 8'd1; tick();
    tick();
    data = 8'd2; tick();
    data = 8'd3; abort = 1'b1; tick();
    abort = 1'b0; valid = 1'b0;
    check("abort {busy,ready,done}", int'({o_busy, o_ready, o_done}), 0);
    check("abort in-flight {enable,o_in}", int'({o_enable, o_in}), {1'b1, 8'd3});
    tick();
    check("after abort enable", int'(o_enable), 0);
    tick();
    check("abort done pulses", done_tot - b_done, 0);
    check("abort enables", en_tot - b_en, 3);
    // Abort is ignored in IDLE: the start still goes through.
    snap();
    abort = 1'b1; start = 1'b1; len = 8'd1; tick();
    abort = 1'b0; start = 1'b0;
    check("abort in IDLE ignored init", int'(o_init), 1);
    valid = 1'b1; data = 8'd9; tick();
    tick();
    check("len1 after idle abort {done,o_in}", int'({o_done, o_in}), {1'b1, 8'd9});
    valid = 1'b0; tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, observed timeout, expected finish");
    $fatal(1);
  end

endmodule
